// File: rtl/popcount_rr_scheduler.sv
// ---------------------------------------------------------------------------
// popcount_rr_scheduler
//
// Shares one external pipelined bit_population_counter among NUM_REQ
// requesters. A round-robin arbiter accepts at most one word per cycle and
// registers it toward the counter. The requester ID of every issued word
// travels through a LATENCY-deep tag pipeline that runs alongside the
// counter. Each returned count is paired with its tag and presented as a
// one-cycle response. A disagreement between the tag valid and the counter
// valid sets a sticky error flag.
//
// Ports
//   clk_i          : clock
//   srst_i         : synchronous active-high reset (also resets the counter)
//   en_i           : grant enable; in-flight words drain while it is low
//   req_data_i     : requester words, slice i = [i*WIDTH +: WIDTH]
//   req_val_i      : per-requester valid
//   req_ready_o    : per-requester ready (combinational, one-hot or zero)
//   pc_data_o      : word to the counter data_i (registered)
//   pc_data_val_o  : valid to the counter data_val_i (registered)
//   pc_data_i      : count from the counter data_o
//   pc_data_val_i  : valid from the counter data_val_o
//   resp_data_o    : returned count (registered)
//   resp_id_o      : requester index of resp_data_o (registered)
//   resp_val_o     : response valid, one-cycle pulse
//   busy_o         : a word is in flight anywhere in the scheduler
//   err_o          : sticky tag/valid mismatch flag
// ---------------------------------------------------------------------------
module popcount_rr_scheduler #(
    parameter  int WIDTH   = 256,
    parameter  int NUM_REQ = 4,
    parameter  int LATENCY = 16,
    localparam int CW      = $clog2(WIDTH) + 1,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic                     en_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]       req_val_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [WIDTH-1:0]         pc_data_o,
    output logic                     pc_data_val_o,
    input  logic [CW-1:0]            pc_data_i,
    input  logic                     pc_data_val_i,
    output logic [CW-1:0]            resp_data_o,
    output logic [IDW-1:0]           resp_id_o,
    output logic                     resp_val_o,
    output logic                     busy_o,
    output logic                     err_o
);

    logic [IDW-1:0]     ptr;
    logic [IDW:0]       cand;
    logic               grant_found;
    logic [IDW-1:0]     grant_id;
    logic               transfer;
    logic [IDW-1:0]     issue_id;
    logic [LATENCY-1:0] tag_valid;
    logic [IDW-1:0]     tag_id [LATENCY];
    logic               tag_last_valid;
    logic [IDW-1:0]     tag_last_id;

    // -----------------------------------------------------------------------
    // Arbitration: scan ptr, ptr+1, ... modulo NUM_REQ. The candidate is
    // kept one bit wider so the wrap works for non-power-of-2 NUM_REQ.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!grant_found && req_val_i[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[IDW-1:0];
            end
        end
    end

    // Ready is only offered when the grant can actually be taken.
    assign transfer = en_i & ~srst_i & grant_found;

    always_comb begin
        req_ready_o = '0;
        if (transfer) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (srst_i) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Issue stage: registered word/valid toward the counter. issue_id
    // carries the owner of pc_data_o into tag stage 0.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pc_data_o     <= '0;
            pc_data_val_o <= 1'b0;
            issue_id      <= '0;
        end else begin
            pc_data_val_o <= transfer;
            if (transfer) begin
                pc_data_o <= req_data_i[int'(grant_id)*WIDTH +: WIDTH];
                issue_id  <= grant_id;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Tag pipeline: stage 0 captures the tag of the word currently on
    // pc_data_o, so the last stage lines up with the counter output.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            tag_valid <= '0;
        end else begin
            tag_valid[0] <= pc_data_val_o;
            for (int s = 1; s < LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
            end
        end
    end

    // NOTE: the ID stages are not reset; they are only consumed when the
    // matching valid bit is set, and that valid chain is reset.
    always_ff @(posedge clk_i) begin
        tag_id[0] <= issue_id;
        for (int s = 1; s < LATENCY; s++) begin
            tag_id[s] <= tag_id[s-1];
        end
    end

    assign tag_last_valid = tag_valid[LATENCY-1];
    assign tag_last_id    = tag_id[LATENCY-1];

    // -----------------------------------------------------------------------
    // Return and mismatch detection. A mismatch in either direction
    // suppresses the response and latches err_o until reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            resp_val_o  <= 1'b0;
            resp_data_o <= '0;
            resp_id_o   <= '0;
            err_o       <= 1'b0;
        end else begin
            resp_val_o <= tag_last_valid & pc_data_val_i;
            if (tag_last_valid && pc_data_val_i) begin
                resp_data_o <= pc_data_i;
                resp_id_o   <= tag_last_id;
            end
            if (tag_last_valid != pc_data_val_i) begin
                err_o <= 1'b1;
            end
        end
    end

    // The response register counts as the final in-flight stage, so busy
    // drops the cycle after the last response pulse.
    assign busy_o = pc_data_val_o | (|tag_valid) | resp_val_o;

endmodule

// File: tb/tb_popcount_rr_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for popcount_rr_scheduler. A behavioural LATENCY-cycle popcount
// counter is attached to the pc_* ports. The reference model tracks the
// round-robin pointer as an integer and keeps a queue of expected responses
// (id, count, due cycle) computed from the accepted words.
// ---------------------------------------------------------------------------
module tb_popcount_rr_scheduler;

    localparam int WIDTH   = 256;
    localparam int NUM_REQ = 4;
    localparam int LATENCY = 16;
    localparam int CW      = $clog2(WIDTH) + 1;
    localparam int IDW     = $clog2(NUM_REQ);

    logic                     clk = 1'b0;
    logic                     srst;
    logic                     en;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_val;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [WIDTH-1:0]         pc_data_o;
    logic                     pc_data_val_o;
    logic [CW-1:0]            pc_data_i;
    logic                     pc_data_val_i;
    logic [CW-1:0]            resp_data_o;
    logic [IDW-1:0]           resp_id_o;
    logic                     resp_val_o;
    logic                     busy_o;
    logic                     err_o;
    logic                     inject;

    always #5 clk = ~clk;

    popcount_rr_scheduler #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ),
        .LATENCY (LATENCY)
    ) dut (
        .clk_i         (clk),
        .srst_i        (srst),
        .en_i          (en),
        .req_data_i    (req_data),
        .req_val_i     (req_val),
        .req_ready_o   (req_ready_o),
        .pc_data_o     (pc_data_o),
        .pc_data_val_o (pc_data_val_o),
        .pc_data_i     (pc_data_i),
        .pc_data_val_i (pc_data_val_i),
        .resp_data_o   (resp_data_o),
        .resp_id_o     (resp_id_o),
        .resp_val_o    (resp_val_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    // Behavioural counter: count available LATENCY cycles after data_val_i.
    logic          cnt_v [LATENCY];
    logic [CW-1:0] cnt_d [LATENCY];

    always @(posedge clk) begin
        if (srst) begin
            for (int s = 0; s < LATENCY; s++) begin
                cnt_v[s] <= 1'b0;
                cnt_d[s] <= '0;
            end
        end else begin
            cnt_v[0] <= pc_data_val_o;
            cnt_d[0] <= CW'($countones(pc_data_o));
            for (int s = 1; s < LATENCY; s++) begin
                cnt_v[s] <= cnt_v[s-1];
                cnt_d[s] <= cnt_d[s-1];
            end
        end
    end

    assign pc_data_val_i = cnt_v[LATENCY-1] | inject;
    assign pc_data_i     = cnt_d[LATENCY-1];

    // Reference model state
    typedef struct {
        int id;
        int cnt;
        int due;
    } exp_t;

    exp_t q[$];
    int   m_ptr;
    bit   m_err;
    int   cyc;
    int   n_cmp;
    int   n_fail;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check ready against the model, advance the model,
    // cross the edge, then check the registered outputs.
    task automatic step();
        int                 g;
        logic [NUM_REQ-1:0] exp_ready;
        bit                 exp_val;
        #1;
        g = -1;
        if (en && !srst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (m_ptr + k) % NUM_REQ;
                if (g < 0 && req_val[i]) g = i;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", WIDTH'(req_ready_o), WIDTH'(exp_ready));
        if (g >= 0) begin
            q.push_back('{g, $countones(req_data[g*WIDTH +: WIDTH]), cyc + LATENCY + 2});
            m_ptr = (g + 1) % NUM_REQ;
        end
        if (inject) m_err = 1'b1;
        if (srst) begin
            q.delete();
            m_ptr = 0;
            m_err = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
        exp_val = (q.size() > 0) && (q[0].due == cyc);
        check("resp_val", WIDTH'(resp_val_o), WIDTH'(exp_val));
        if (exp_val) begin
            check("resp_data", WIDTH'(resp_data_o), WIDTH'(q[0].cnt));
            check("resp_id", WIDTH'(resp_id_o), WIDTH'(q[0].id));
            void'(q.pop_front());
        end
        check("err", WIDTH'(err_o), WIDTH'(m_err));
        check("busy", WIDTH'(busy_o), WIDTH'((q.size() > 0) || exp_val));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_data();
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < WIDTH / 32; j++) begin
                req_data[i*WIDTH + j*32 +: 32] = $urandom;
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        m_ptr  = 0;
        m_err  = 1'b0;
        srst   = 1'b1;
        en     = 1'b1;
        inject = 1'b0;
        req_val = '1;
        rand_data();

        // Reset held 3 cycles with every requester valid.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_pc_data", pc_data_o, '0);
            check("rst_pc_val", WIDTH'(pc_data_val_o), '0);
            check("rst_resp_data", WIDTH'(resp_data_o), '0);
            check("rst_resp_id", WIDTH'(resp_id_o), '0);
        end
        srst    = 1'b0;
        req_val = '0;

        // Single request: requester 2 sends 0xFF once.
        req_data = '0;
        req_data[2*WIDTH +: 8] = 8'hFF;
        req_val = 4'b0100;
        step();
        check("single_issue_val", WIDTH'(pc_data_val_o), WIDTH'(1));
        check("single_issue_data", pc_data_o, WIDTH'(8'hFF));
        req_val = '0;
        steps(LATENCY + 4);

        // Full contention from ptr=0, words of popcount 1..4.
        srst = 1'b1;
        step();
        srst = 1'b0;
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j <= i; j++) req_data[i*WIDTH + j] = 1'b1;
        end
        req_val = '1;
        steps(24);
        req_val = '0;
        steps(LATENCY + 4);

        // Fairness and wrap: move ptr to 3, then 3 and 0 alternate; raising 1
        // once ptr reaches 1 serves it ahead of 3.
        rand_data();
        req_val = 4'b0100;
        step();
        req_val = 4'b1001;
        steps(6);
        req_val = 4'b1011;
        steps(4);
        req_val = '0;
        steps(LATENCY + 4);

        // Enable dropped mid-stream for 5 cycles; in-flight words drain.
        for (int i = 0; i < 8; i++) begin
            rand_data();
            req_val = NUM_REQ'($urandom_range(1, 15));
            step();
        end
        en = 1'b0;
        steps(5);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            req_val = NUM_REQ'($urandom_range(1, 15));
            step();
        end

        // Reset with 10 words in flight: nothing returns, no error.
        req_val = '1;
        for (int i = 0; i < 10; i++) begin
            rand_data();
            step();
        end
        req_val = '0;
        srst = 1'b1;
        step();
        srst = 1'b0;
        steps(LATENCY + 6);

        // Mismatch: counter valid with an empty tag pipeline.
        inject = 1'b1;
        step();
        inject = 1'b0;
        steps(6);
        srst = 1'b1;
        step();
        srst = 1'b0;
        steps(2);

        // Randomized traffic with occasional enable drops.
        for (int i = 0; i < 300; i++) begin
            rand_data();
            req_val = NUM_REQ'($urandom_range(0, 15));
            en = ($urandom_range(0, 9) != 0);
            step();
        end
        en = 1'b1;
        req_val = '0;
        steps(LATENCY + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/popcount_rr_scheduler.md
# popcount_rr_scheduler

Round-robin scheduler that shares one pipelined `bit_population_counter` instance among `NUM_REQ` requesters. Each cycle it accepts at most one word and issues it to the counter. It tracks the requester ID of every in-flight word in a fixed-latency tag pipeline. It returns each count to the originating requester with its ID and flags any protocol mismatch.

## Interface

**Parameters**
- `WIDTH`, default 256: data word width, matching the counter's `WIDTH`.
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `LATENCY`, default 16: cycles from counter `data_val_i` to counter `data_val_o`, ≥1. Must equal the attached counter's latency.
- Derived: `CW = $clog2(WIDTH)+1`; `IDW = $clog2(NUM_REQ)`.

**Ports**
- `clk_i` in 1: single clock.
- `srst_i` in 1: synchronous, active-high reset. Shared with the attached counter.
- `en_i` in 1: grant enable. When 0, no new requests are accepted; in-flight words still drain.
- `req_data_i` in `NUM_REQ*WIDTH`: requester words. Slice `i` is `[i*WIDTH +: WIDTH]`.
- `req_val_i` in `NUM_REQ`: per-requester valid.
- `req_ready_o` out `NUM_REQ`: per-requester ready. Combinational, one-hot or zero.
- `pc_data_o` out `WIDTH`: word to counter `data_i`. Registered.
- `pc_data_val_o` out 1: to counter `data_val_i`. Registered.
- `pc_data_i` in `CW`: from counter `data_o`.
- `pc_data_val_i` in 1: from counter `data_val_o`.
- `resp_data_o` out `CW`: returned count. Registered.
- `resp_id_o` out `IDW`: requester index for `resp_data_o`. Registered.
- `resp_val_o` out 1: response valid, single-cycle pulse. No backpressure.
- `busy_o` out 1: high while any word is in flight (tag pipeline non-empty or output stage valid).
- `err_o` out 1: sticky tag/valid mismatch flag. Cleared only by `srst_i`.

## Operation

- **Arbitration**
  - Round-robin priority pointer `ptr`, `IDW` bits, reset to 0.
  - Grant goes to the first `i` in order `ptr, ptr+1, … (mod NUM_REQ)` with `req_val_i[i]=1`, and only when `en_i=1` and `srst_i=0`.
  - `req_ready_o[i]=1` only for the granted `i`; a transfer occurs when `req_val_i[i] & req_ready_o[i]`.
  - After a transfer to `i`, `ptr <= (i+1) mod NUM_REQ`. With no transfer, `ptr` holds.
  - `ptr` wrap-around at `NUM_REQ-1` goes to 0, including non-power-of-2 `NUM_REQ`. Values ≥`NUM_REQ` never occur.
- **Issue**
  - On transfer: `pc_data_o <= req_data_i[i]`, `pc_data_val_o <= 1`.
  - Otherwise `pc_data_val_o <= 0` and `pc_data_o` holds its value.
- **Tag pipeline**
  - `LATENCY`-stage shift register of `{valid, id}`. Stage 0 loads `{pc_data_val_o, id of issued word}` in the same cycle `pc_data_o` is presented.
  - It advances every cycle and is never stalled.
- **Return**
  - When the tag pipeline's last-stage valid is 1 and `pc_data_val_i=1`: `resp_val_o <= 1`, `resp_data_o <= pc_data_i`, `resp_id_o <= tag id`.
- **Mismatch**
  - If `pc_data_val_i` differs from the last-stage valid, `err_o <= 1` and no response is produced that cycle.
  - Either direction counts: count without tag, or tag without count.
- **Reset**
  - `srst_i` clears `ptr`, all tag stages, `pc_data_val_o`, `resp_val_o`, and `err_o` in the same cycle.
  - Words in flight at reset are discarded; the counter is reset by the same signal.

## Timing

- Reset values: `req_ready_o=0` while `srst_i=1`. `pc_data_o=0`, `pc_data_val_o=0`, `resp_data_o=0`, `resp_id_o=0`, `resp_val_o=0`, `busy_o=0`, `err_o=0`.
- Accept at edge N → `pc_data_val_o` high during cycle N+1 → `pc_data_val_i` at N+1+`LATENCY` → `resp_val_o` at N+2+`LATENCY`.
- End-to-end latency is exactly `LATENCY+2` cycles. Throughput is 1 word/cycle aggregate.
- Responses return in acceptance order. No reordering, no drops absent error.
- `en_i` falling: no accept in that same cycle. `busy_o` falls the cycle after the last `resp_val_o`.
- `srst_i` asserted mid-stream: no `resp_val_o` for words accepted before reset, even if the counter emits them.

## Test plan

- **Reset:** hold `srst_i` 3 cycles with all `req_val_i=1` → all outputs 0, no `req_ready_o`, no `pc_data_val_o`.
- **Single request:** `NUM_REQ=4`, `LATENCY=16`, requester 2 sends `0xFF` once → `resp_val_o` 18 cycles after accept with `resp_data_o=8`, `resp_id_o=2`; `busy_o` low afterwards.
- **Full contention:** all 4 requesters continuously valid with words of popcount 1, 2, 3, 4 → grants follow 0,1,2,3,0,…; responses repeat (id,count) = (0,1),(1,2),(2,3),(3,4) back-to-back, 1 per cycle, no error.
- **Fairness/wrap:** only requesters 3 and 0 valid, `ptr=3` → grants alternate 3,0,3,0; requester 1 raised later is served before 3 once `ptr` reaches 1.
- **Enable and reset mid-stream:** drop `en_i` for 5 cycles mid-stream → no accepts, in-flight words still return. Then assert `srst_i` with 10 words in flight → zero responses, `err_o` stays 0.
- **Mismatch:** inject `pc_data_val_i=1` with empty tag pipeline → `err_o` rises next cycle and stays high until `srst_i`; no `resp_val_o`.
